// File: rtl/adder_rr_scheduler_if.sv
// Bundle between the scheduler, its requesters and the shared adder.
// Handshake: a request transfers in the cycle where req_valid[i] and req_ready[i] are both 1.
interface adder_rr_scheduler_if #(
    parameter int W  = 10,
    parameter int N  = 4,
    parameter int IW = (N > 1) ? $clog2(N) : 1
);
    logic [N-1:0]   req_valid;
    logic [N*W-1:0] req_a;
    logic [N*W-1:0] req_b;
    logic [N-1:0]   req_ready;
    logic           add_start;
    logic [W-1:0]   add_a;
    logic [W-1:0]   add_b;
    logic [W-1:0]   add_y;
    logic           add_valid;
    logic           rsp_valid;
    logic [IW-1:0]  rsp_id;
    logic [W-1:0]   rsp_y;
    logic           rsp_err;

    modport slave (
        input  req_valid, req_a, req_b, add_y, add_valid,
        output req_ready, add_start, add_a, add_b, rsp_valid, rsp_id, rsp_y, rsp_err
    );

    modport master (
        output req_valid, req_a, req_b, add_y, add_valid,
        input  req_ready, add_start, add_a, add_b, rsp_valid, rsp_id, rsp_y, rsp_err
    );
endinterface

// File: rtl/adder_rr_scheduler.sv
// Round-robin scheduler sharing one registered adder among N requesters,
// with per-operation timeout supervision and tagged responses.
module adder_rr_scheduler #(
    parameter int W       = 10,
    parameter int N       = 4,
    parameter int TIMEOUT = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    adder_rr_scheduler_if.slave  bus,
    output logic                 o_busy,
    output logic                 o_timeout_err,
    output logic [15:0]          o_ops_done,
    output logic [1:0]           o_dbg_state
);
    localparam int IW = (N > 1) ? $clog2(N) : 1;
    localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0] WC_LAST = CW'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic [IW-1:0]   r_ptr;
    logic [IW-1:0]   r_tag;
    logic [CW-1:0]   r_wcnt;
    logic [IW-1:0]   w_grant;
    logic            w_any;
    logic            w_timeout;
    logic [IW-1:0]   w_ptr_nxt;

    // First pending requester at or above ptr, wrapping modulo N.
    always_comb begin
        int idx;
        idx     = 0;
        w_any   = 1'b0;
        w_grant = '0;
        for (int k = 0; k < N; k++) begin
            idx = (int'(r_ptr) + k) % N;
            if (!w_any && bus.req_valid[idx]) begin
                w_any   = 1'b1;
                w_grant = IW'(idx);
            end
        end
    end

    assign w_ptr_nxt = IW'((int'(w_grant) + 1) % N);
    assign w_timeout = (r_wcnt == WC_LAST) && !bus.add_valid;

    always_comb begin
        bus.req_ready = '0;
        if (r_state == S_IDLE && w_any) begin
            bus.req_ready[w_grant] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (w_any) w_state_nxt = S_ISSUE;
            S_ISSUE: w_state_nxt = S_WAIT;
            S_WAIT:  if (bus.add_valid || w_timeout) w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Pulses (add_start, rsp_valid, rsp_err) self-clear unless re-armed this cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.add_start <= 1'b0;
            bus.add_a     <= '0;
            bus.add_b     <= '0;
            bus.rsp_valid <= 1'b0;
            bus.rsp_id    <= '0;
            bus.rsp_y     <= '0;
            bus.rsp_err   <= 1'b0;
            o_timeout_err <= 1'b0;
            o_ops_done    <= '0;
            r_ptr         <= '0;
            r_tag         <= '0;
            r_wcnt        <= '0;
        end else begin
            bus.add_start <= 1'b0;
            bus.rsp_valid <= 1'b0;
            bus.rsp_err   <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_any) begin
                        bus.add_a     <= bus.req_a[w_grant*W +: W];
                        bus.add_b     <= bus.req_b[w_grant*W +: W];
                        r_tag         <= w_grant;
                        r_ptr         <= w_ptr_nxt;
                        bus.add_start <= 1'b1;
                    end
                end
                S_ISSUE: begin
                    r_wcnt <= '0;
                end
                S_WAIT: begin
                    if (bus.add_valid) begin
                        bus.rsp_valid <= 1'b1;
                        bus.rsp_y     <= bus.add_y;
                        bus.rsp_id    <= r_tag;
                        o_ops_done    <= o_ops_done + 16'd1;
                    end else if (w_timeout) begin
                        bus.rsp_valid <= 1'b1;
                        bus.rsp_err   <= 1'b1;
                        bus.rsp_y     <= '0;
                        bus.rsp_id    <= r_tag;
                        o_timeout_err <= 1'b1;
                    end else begin
                        r_wcnt <= r_wcnt + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign o_busy      = (r_state != S_IDLE);
    assign o_dbg_state = r_state;
endmodule
